// File: rtl/toecam_bucket_lookup.sv
// Linear-probing bucket lookup behind the ToeCam hash stage; one lookup in flight.
// Optional hit/miss/full statistics counters are enabled by TOECAM_LOOKUP_STATS_EN.
module toecam_bucket_lookup #(
    parameter int unsigned K          = 97,
    parameter int unsigned H          = 48,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned V_W        = 14,
    parameter int unsigned MAX_PROBES = 4
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               LkpReqValid,
    output logic               LkpReqReady,
    input  logic [K-1:0]       LkpReqKey,
    input  logic [H-1:0]       LkpReqHash,
    output logic               MemRdEn,
    output logic [ADDR_W-1:0]  MemRdAddr,
    input  logic [K+V_W:0]     MemRdData,
    output logic               LkpRspValid,
    input  logic               LkpRspReady,
    output logic               LkpRspHit,
    output logic               LkpRspFull,
    output logic [V_W-1:0]     LkpRspValue,
    output logic [ADDR_W-1:0]  LkpRspAddr
`ifdef TOECAM_LOOKUP_STATS_EN
    ,
    output logic [31:0]        StatHitCnt,
    output logic [31:0]        StatMissCnt,
    output logic [31:0]        StatFullCnt
`endif
);

    localparam int unsigned PW = $clog2(MAX_PROBES) + 1;
    localparam logic [PW-1:0] LastProbe = PW'(MAX_PROBES - 1);

    typedef enum logic [1:0] {StIdle, StRd, StCmp, StRsp} state_e;

    state_e            state_q;
    logic [K-1:0]      key_q;
    logic [ADDR_W-1:0] base_q;
    logic [PW-1:0]     probe_q;

    logic              slot_valid;
    logic [K-1:0]      slot_key;
    logic [V_W-1:0]    slot_value;
    logic [PW-1:0]     probe_nxt;
    logic              unused_hash;

    assign slot_valid  = MemRdData[K+V_W];
    assign slot_key    = MemRdData[V_W +: K];
    assign slot_value  = MemRdData[V_W-1:0];
    assign probe_nxt   = probe_q + 1'b1;
    // Only the low hash bits index the table; the rest is never compared.
    assign unused_hash = ^LkpReqHash;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= StIdle;
            key_q       <= '0;
            base_q      <= '0;
            probe_q     <= '0;
            LkpReqReady <= 1'b1;
            MemRdEn     <= 1'b0;
            MemRdAddr   <= '0;
            LkpRspValid <= 1'b0;
            LkpRspHit   <= 1'b0;
            LkpRspFull  <= 1'b0;
            LkpRspValue <= '0;
            LkpRspAddr  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (LkpReqValid) begin
                        key_q       <= LkpReqKey;
                        base_q      <= LkpReqHash[ADDR_W-1:0];
                        probe_q     <= '0;
                        LkpReqReady <= 1'b0;
                        MemRdEn     <= 1'b1;
                        MemRdAddr   <= LkpReqHash[ADDR_W-1:0];
                        state_q     <= StRd;
                    end
                end
                StRd: begin
                    MemRdEn <= 1'b0;
                    state_q <= StCmp;
                end
                StCmp: begin
                    if (!slot_valid) begin
                        // Empty slot ends the probe chain.
                        LkpRspValid <= 1'b1;
                        LkpRspHit   <= 1'b0;
                        LkpRspFull  <= 1'b0;
                        LkpRspValue <= '0;
                        LkpRspAddr  <= MemRdAddr;
                        state_q     <= StRsp;
                    end else if (slot_key == key_q) begin
                        LkpRspValid <= 1'b1;
                        LkpRspHit   <= 1'b1;
                        LkpRspFull  <= 1'b0;
                        LkpRspValue <= slot_value;
                        LkpRspAddr  <= MemRdAddr;
                        state_q     <= StRsp;
                    end else if (probe_q == LastProbe) begin
                        LkpRspValid <= 1'b1;
                        LkpRspHit   <= 1'b0;
                        LkpRspFull  <= 1'b1;
                        LkpRspValue <= '0;
                        LkpRspAddr  <= base_q;
                        state_q     <= StRsp;
                    end else begin
                        probe_q   <= probe_nxt;
                        MemRdEn   <= 1'b1;
                        MemRdAddr <= base_q + ADDR_W'(probe_nxt);
                        state_q   <= StRd;
                    end
                end
                StRsp: begin
                    if (LkpRspReady) begin
                        LkpRspValid <= 1'b0;
                        LkpReqReady <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef TOECAM_LOOKUP_STATS_EN
    logic rsp_done;
    assign rsp_done = (state_q == StRsp) && LkpRspReady;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            StatHitCnt  <= '0;
            StatMissCnt <= '0;
            StatFullCnt <= '0;
        end else if (rsp_done) begin
            if (LkpRspHit && StatHitCnt != '1) begin
                StatHitCnt <= StatHitCnt + 32'd1;
            end
            if (!LkpRspHit && StatMissCnt != '1) begin
                StatMissCnt <= StatMissCnt + 32'd1;
            end
            if (LkpRspFull && StatFullCnt != '1) begin
                StatFullCnt <= StatFullCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_toecam_bucket_lookup.sv
// Directed bench for toecam_bucket_lookup with a registered single-port RAM model.
module tb_toecam_bucket_lookup;

    localparam int unsigned D_W = 1 + 97 + 14;

    localparam logic [96:0] KEY_A  = 97'h1_23456789_ABCDEF01_23456789;
    localparam logic [96:0] KEY_AX = 97'h0_23456789_ABCDEF01_23456789;
    localparam logic [96:0] KEY_B  = 97'h0_DEADBEEF_CAFEF00D_01234567;
    localparam logic [96:0] KEY_C  = 97'h0_11111111_22222222_33333333;
    localparam logic [96:0] KEY_D  = 97'h1_44444444_55555555_66666666;

    logic            Clk = 1'b0;
    logic            Rst_n;
    logic            LkpReqValid;
    logic            LkpReqReady;
    logic [96:0]     LkpReqKey;
    logic [47:0]     LkpReqHash;
    logic            MemRdEn;
    logic [11:0]     MemRdAddr;
    logic [D_W-1:0]  MemRdData;
    logic            LkpRspValid;
    logic            LkpRspReady;
    logic            LkpRspHit;
    logic            LkpRspFull;
    logic [13:0]     LkpRspValue;
    logic [11:0]     LkpRspAddr;
`ifdef TOECAM_LOOKUP_STATS_EN
    logic [31:0]     StatHitCnt;
    logic [31:0]     StatMissCnt;
    logic [31:0]     StatFullCnt;
`endif

    always #5 Clk = ~Clk;

    toecam_bucket_lookup dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .LkpReqValid (LkpReqValid),
        .LkpReqReady (LkpReqReady),
        .LkpReqKey   (LkpReqKey),
        .LkpReqHash  (LkpReqHash),
        .MemRdEn     (MemRdEn),
        .MemRdAddr   (MemRdAddr),
        .MemRdData   (MemRdData),
        .LkpRspValid (LkpRspValid),
        .LkpRspReady (LkpRspReady),
        .LkpRspHit   (LkpRspHit),
        .LkpRspFull  (LkpRspFull),
        .LkpRspValue (LkpRspValue),
        .LkpRspAddr  (LkpRspAddr)
`ifdef TOECAM_LOOKUP_STATS_EN
        ,
        .StatHitCnt  (StatHitCnt),
        .StatMissCnt (StatMissCnt),
        .StatFullCnt (StatFullCnt)
`endif
    );

    logic [D_W-1:0] mem [0:4095];

    always @(posedge Clk) begin
        if (MemRdEn) MemRdData <= mem[MemRdAddr];
    end

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    int nrd;
    logic [11:0] rd_addr [0:15];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [D_W-1:0] slot(input logic v, input logic [96:0] k,
                                            input logic [13:0] val);
        return {v, k, val};
    endfunction

    // Issue one request, then sample every cycle until the response shows up.
    // lat counts cycles after the acceptance edge; reads are logged in rd_addr.
    task automatic lookup(input logic [96:0] key, input logic [47:0] hash);
        bit seen;
        @(negedge Clk);
        check("req_ready_idle", {127'd0, LkpReqReady}, 128'd1);
        LkpReqValid = 1'b1;
        LkpReqKey   = key;
        LkpReqHash  = hash;
        @(posedge Clk);
        @(negedge Clk);
        LkpReqValid = 1'b0;
        nrd  = 0;
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            if (c > 1) @(negedge Clk);
            if (MemRdEn) begin
                if (nrd < 16) rd_addr[nrd] = MemRdAddr;
                nrd++;
            end
            if (LkpRspValid) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        if (!seen) check("rsp_timeout", 128'd0, 128'd1);
    endtask

    task automatic finish_rsp(input string tag);
        @(negedge Clk);
        check(tag, {125'd0, LkpReqReady, LkpRspValid, MemRdEn}, {125'd0, 3'b100});
    endtask

    initial begin
        int rsp_seen;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        MemRdData   = '0;
        Rst_n       = 1'b0;
        LkpReqValid = 1'b0;
        LkpReqKey   = '0;
        LkpReqHash  = '0;
        LkpRspReady = 1'b1;

        mem[12'h123] = slot(1'b1, KEY_A, 14'h2A5);
        mem[12'hFFE] = slot(1'b1, KEY_C, 14'h001);
        mem[12'hFFF] = slot(1'b1, KEY_D, 14'h002);
        mem[12'h000] = slot(1'b1, KEY_B, 14'h01B);
        mem[12'h010] = slot(1'b1, KEY_C, 14'h005);
        mem[12'h200] = slot(1'b1, KEY_AX, 14'h011);
        mem[12'h201] = slot(1'b1, KEY_B, 14'h012);
        mem[12'h202] = slot(1'b1, KEY_C, 14'h013);
        mem[12'h203] = slot(1'b1, KEY_D, 14'h014);

        // Reset values
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("rst_req_ready", {127'd0, LkpReqReady}, 128'd1);
        check("rst_mem", {115'd0, MemRdEn, MemRdAddr}, 128'd0);
        check("rst_rsp", {98'd0, LkpRspValid, LkpRspHit, LkpRspFull, LkpRspValue, LkpRspAddr},
              128'd0);

        // Reset asserted while the lookup sits in CMP: request is dropped
        LkpReqValid = 1'b1;
        LkpReqKey   = KEY_A;
        LkpReqHash  = 48'h0000_0000_0123;
        @(posedge Clk);
        @(negedge Clk);
        LkpReqValid = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check("midcmp_rst_rsp_valid", {127'd0, LkpRspValid}, 128'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        rsp_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (LkpRspValid) rsp_seen++;
        end
        check("midcmp_no_rsp", rsp_seen, 0);
        check("midcmp_idle", {126'd0, LkpReqReady, MemRdEn}, 128'b10);

        // First-probe hit
        lookup(KEY_A, 48'h5A5A_0000_0123);
        check("hit_lat", lat, 3);
        check("hit_nrd", nrd, 1);
        check("hit_rd0", rd_addr[0], 12'h123);
        check("hit_rsp", {LkpRspHit, LkpRspFull, LkpRspValue, LkpRspAddr},
              {1'b1, 1'b0, 14'h2A5, 12'h123});
        finish_rsp("hit_done");

        // Probe chain wraps past the top slot
        lookup(KEY_B, 48'hABCD_EF12_3FFE);
        check("wrap_lat", lat, 7);
        check("wrap_nrd", nrd, 3);
        check("wrap_rds", {rd_addr[0], rd_addr[1], rd_addr[2]}, {12'hFFE, 12'hFFF, 12'h000});
        check("wrap_rsp", {LkpRspHit, LkpRspFull, LkpRspValue, LkpRspAddr},
              {1'b1, 1'b0, 14'h01B, 12'h000});
        finish_rsp("wrap_done");

        // Miss terminated by an empty slot
        lookup(KEY_B, 48'h0000_0F00_0010);
        check("empty_lat", lat, 5);
        check("empty_rds", {nrd[3:0], rd_addr[0], rd_addr[1]}, {4'd2, 12'h010, 12'h011});
        check("empty_rsp", {LkpRspHit, LkpRspFull, LkpRspValue, LkpRspAddr},
              {1'b0, 1'b0, 14'h000, 12'h011});
        finish_rsp("empty_done");

        // Full miss; slot 0x200 differs from KEY_A only in the key MSB
        lookup(KEY_A, 48'h1234_5678_9200);
        check("full_lat", lat, 9);
        check("full_nrd", nrd, 4);
        check("full_rds", {rd_addr[0], rd_addr[1], rd_addr[2], rd_addr[3]},
              {12'h200, 12'h201, 12'h202, 12'h203});
        check("full_rsp", {LkpRspHit, LkpRspFull, LkpRspValue, LkpRspAddr},
              {1'b0, 1'b1, 14'h000, 12'h200});
        finish_rsp("full_done");
`ifdef TOECAM_LOOKUP_STATS_EN
        check("stat_after_full", {32'd0, StatHitCnt, StatMissCnt, StatFullCnt},
              {32'd0, 32'd2, 32'd2, 32'd1});
`endif

        // Backpressured hit response
        LkpRspReady = 1'b0;
        lookup(KEY_A, 48'h0000_0000_0123);
        check("bp_lat", lat, 3);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge Clk);
            check("bp_hold", {LkpRspHit, LkpRspFull, LkpRspValue, LkpRspAddr, LkpReqReady, MemRdEn,
                              LkpRspValid},
                  {1'b1, 1'b0, 14'h2A5, 12'h123, 1'b0, 1'b0, 1'b1});
        end
        @(negedge Clk);
        LkpRspReady = 1'b1;
        check("bp_cycle11", {126'd0, LkpRspValid, LkpReqReady}, 128'b10);
        finish_rsp("bp_done");
`ifdef TOECAM_LOOKUP_STATS_EN
        check("stat_end", {32'd0, StatHitCnt, StatMissCnt, StatFullCnt},
              {32'd0, 32'd3, 32'd2, 32'd1});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
